// File: rtl/tao_ifu.sv
// Instruction fetch unit: fetches one 32-bit word per retired instruction over a
// valid/ready memory port and hands {inst, inst_pc} to decode; sticky fault on error/timeout.
module tao_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        mem_rsp_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_BOOT, S_REQ, S_RSP, S_OUT, S_WAITPC, S_ERR
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [15:0] timer;
  logic        pc_aligned;
  logic        timed_out;

  assign pc_aligned   = (pc_in[1:0] == 2'b00);
  assign timed_out    = (TIMEOUT != 16'd0) && (timer == TIMEOUT - 16'd1);
  assign mem_req_addr = fetch_pc;

  // Single-process FSM; every valid/ready output is a flop updated on its transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_BOOT;
      fetch_pc      <= RESET_PC;
      inst          <= 32'd0;
      inst_pc       <= 32'd0;
      fetch_cnt     <= 32'd0;
      timer         <= 16'd0;
      fetch_err     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_rsp_ready <= 1'b0;
      inst_valid    <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state         <= S_REQ;
          mem_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_RSP;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            timer         <= 16'd0;
          end
        end
        S_RSP: begin
          timer <= timer + 16'd1;
          // A good response wins over a timeout landing in the same cycle.
          if (mem_rsp_valid && !mem_rsp_err) begin
            state         <= S_OUT;
            inst          <= mem_rsp_data;
            inst_pc       <= fetch_pc;
            mem_rsp_ready <= 1'b0;
            inst_valid    <= 1'b1;
          end else if (mem_rsp_valid || timed_out) begin
            state         <= S_ERR;
            mem_rsp_ready <= 1'b0;
            fetch_err     <= 1'b1;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
            if (pc_valid && pc_aligned) begin
              state         <= S_REQ;
              fetch_pc      <= pc_in;
              mem_req_valid <= 1'b1;
            end else if (pc_valid) begin
              state     <= S_ERR;
              fetch_err <= 1'b1;
            end else begin
              state <= S_WAITPC;
            end
          end
        end
        S_WAITPC: begin
          if (pc_valid && pc_aligned) begin
            state         <= S_REQ;
            fetch_pc      <= pc_in;
            mem_req_valid <= 1'b1;
          end else if (pc_valid) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
          end
        end
        S_ERR: begin
          mem_req_valid <= 1'b0;
          mem_rsp_ready <= 1'b0;
          inst_valid    <= 1'b0;
          fetch_err     <= 1'b1;
        end
        default: begin
          state     <= S_ERR;
          fetch_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tao_ifu.sv
// Self-checking bench for tao_ifu: directed corner sequences, a pc-acceptance table,
// and a randomized run checked against a transaction-level fetch model.
module tb_tao_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        mem_rsp_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  tao_ifu #(.RESET_PC(RST_PC), .TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .mem_rsp_ready(mem_rsp_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Reset held two cycles, checked, then released just after an edge (cycle 0 = S_BOOT).
  task automatic do_reset();
    rst = 1'b0;
    pc_in = 32'd0; pc_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'd0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        same_cycle;
    logic        exp_err;
  } pc_vec_t;

  pc_vec_t vecs[6];

  // Random-phase model state
  logic [31:0] exp_pc, out_addr, tmp;
  logic [31:0] cnt_model;
  bit outstanding, need_pc, inst_due, req_due, inst_hs, req_hs, rsp_hs, accepted;
  int rsp_delay, pc_wait, idle;

  initial begin
    vecs[0] = '{32'h8000_0004, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0006, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_1000, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0001, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0003, 1'b0, 1'b1};

    // Zero-wait first fetch
    do_reset();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0010_0093;
    tick();
    chk("c1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("c1_req_addr", mem_req_addr, RST_PC);
    tick();
    chk("c2_rsp_ready", 32'(mem_rsp_ready), 32'd1);
    chk("c2_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    chk("c3_inst_valid", 32'(inst_valid), 32'd1);
    chk("c3_inst", inst, 32'h0010_0093);
    chk("c3_inst_pc", inst_pc, RST_PC);

    // Decode stall: output held, count bumps once on release
    mem_rsp_data = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_pc", inst_pc, RST_PC);
      chk("stall_cnt", fetch_cnt, 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("release_valid", 32'(inst_valid), 32'd0);
    chk("release_cnt", fetch_cnt, 32'd1);
    tick(); tick();
    chk("waitpc_cnt", fetch_cnt, 32'd1);
    chk("waitpc_noreq", 32'(mem_req_valid), 32'd0);

    // pc_valid in S_WAITPC with memory back-pressure
    begin
      int nreq = 0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      pc_in = 32'h8000_0004; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0; pc_in = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
        chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
        chk("bp_req_addr", mem_req_addr, 32'h8000_0004);
        tick();
      end
      mem_req_ready = 1'b1;
      if (mem_req_valid) nreq++;
      tick();
      mem_req_ready = 1'b0;
      if (mem_req_valid) nreq++;
      chk("bp_single_req", 32'(nreq), 32'd1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
      tick();
      mem_rsp_valid = 1'b0;
      chk("bp_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h0000_0013);
      chk("bp_inst_pc", inst_pc, 32'h8000_0004);
    end

    // pc acceptance table
    foreach (vecs[k]) begin
      do_reset();
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013;
      tick(); tick(); tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      inst_ready = 1'b1;
      if (vecs[k].same_cycle) begin
        pc_in = vecs[k].pc; pc_valid = 1'b1;
        tick();
      end else begin
        tick();
        inst_ready = 1'b0;
        pc_in = vecs[k].pc; pc_valid = 1'b1;
        tick();
      end
      inst_ready = 1'b0; pc_valid = 1'b0;
      chk("tab_err", 32'(fetch_err), 32'(vecs[k].exp_err));
      chk("tab_req_valid", 32'(mem_req_valid), 32'(!vecs[k].exp_err));
      if (!vecs[k].exp_err) chk("tab_req_addr", mem_req_addr, vecs[k].pc);
      if (vecs[k].exp_err) begin
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; pc_in = 32'h8000_0100; pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("tab_err_sticky", 32'(fetch_err), 32'd1);
          chk("tab_err_noreq", 32'(mem_req_valid), 32'd0);
          chk("tab_err_noinst", 32'(inst_valid), 32'd0);
        end
        pc_valid = 1'b0;
      end
    end

    // Error response
    do_reset();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
    tick(); tick(); tick();
    chk("rsperr_err", 32'(fetch_err), 32'd1);
    mem_rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rsperr_noinst", 32'(inst_valid), 32'd0);
      tick();
    end

    // Timeout: 8 cycles in S_RSP without a response
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    chk("to_before_err", 32'(fetch_err), 32'd0);
    chk("to_before_ready", 32'(mem_rsp_ready), 32'd1);
    tick();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_ready", 32'(mem_rsp_ready), 32'd0);
    mem_rsp_valid = 1'b1;
    tick(); tick();
    chk("to_noinst", 32'(inst_valid), 32'd0);
    mem_rsp_valid = 1'b0;

    // Asynchronous reset during S_RSP
    do_reset();
    mem_req_ready = 1'b1;
    tick(); tick();
    chk("ar_in_rsp", 32'(mem_rsp_ready), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("ar_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    chk("ar_req_valid", 32'(mem_req_valid), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_refetch_valid", 32'(mem_req_valid), 32'd1);
    chk("ar_refetch_addr", mem_req_addr, RST_PC);

    // Randomized run against a transaction-level model
    do_reset();
    exp_pc = RST_PC; cnt_model = 32'd0;
    outstanding = 0; need_pc = 0; inst_due = 0; req_due = 0;
    rsp_delay = 0; pc_wait = 0; idle = 0; out_addr = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (fetch_err) chk("rnd_no_err", 32'(fetch_err), 32'd0);
      if (inst_due) chk("rnd_inst_latency", 32'(inst_valid), 32'd1);
      if (req_due) chk("rnd_req_latency", 32'(mem_req_valid), 32'd1);
      inst_due = 0; req_due = 0;
      if (mem_req_valid) begin
        chk("rnd_req_addr", mem_req_addr, exp_pc);
        chk("rnd_one_inflight", {30'd0, outstanding, need_pc}, 32'd0);
      end
      if (inst_valid) begin
        chk("rnd_inst", inst, mem_word(exp_pc));
        chk("rnd_inst_pc", inst_pc, exp_pc);
      end

      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = outstanding && (rsp_delay == 0);
      mem_rsp_data  = mem_rsp_valid ? mem_word(out_addr) : $urandom;
      mem_rsp_err   = 1'b0;
      inst_ready    = ($urandom_range(0, 2) != 0);
      pc_valid = 1'b0; pc_in = $urandom;
      inst_hs  = inst_valid && inst_ready;
      accepted = 0;
      if (inst_hs) begin
        chk("rnd_cnt", fetch_cnt, cnt_model);
        cnt_model = cnt_model + 32'd1;
        pc_wait = $urandom_range(0, 3);
        idle = 0;
      end
      if (inst_hs || need_pc) begin
        if (pc_wait == 0) begin
          tmp = $urandom;
          pc_in = {tmp[31:2], 2'b00};
          pc_valid = 1'b1;
          accepted = 1;
        end else begin
          pc_wait--;
        end
        need_pc = !accepted;
      end else if ($urandom_range(0, 3) == 0) begin
        pc_valid = 1'b1;
      end
      req_hs = mem_req_valid && mem_req_ready;
      rsp_hs = mem_rsp_valid && mem_rsp_ready;
      if (rsp_hs) begin
        outstanding = 0;
        inst_due = 1;
      end else if (outstanding && rsp_delay > 0) begin
        rsp_delay--;
      end
      if (req_hs) begin
        outstanding = 1;
        out_addr = exp_pc;
        rsp_delay = $urandom_range(0, 5);
      end
      if (accepted) begin
        exp_pc = pc_in;
        req_due = 1;
      end
      tick();
      idle++;
      if (idle > 60) begin
        chk("rnd_progress", 32'(idle), 32'd0);
        break;
      end
    end
    chk("rnd_total_cnt_nonzero", 32'(cnt_model > 32'd100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
